memory: RTL and testbench

Single-port synchronous-write, asynchronous-read RAM of 2048 x 16-bit words (4 KiB), used as the processor's unified instruction/data store. Writes commit on the rising clock edge when enabled. Reads are combinational from the current address. A synchronous active-high reset clears the whole array.

---
 rtl/memory.sv | 55 +++++
 tb/tb_memory.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
//  Module   : memory
//  Purpose  : Single-port RAM, 2**ADDR_WIDTH x DATA_WIDTH words, used as the
//             processor's unified instruction/data store. Writes commit on the
//             rising clock edge. Reads are combinational from the current
//             address. A synchronous reset clears the whole array.
//
//  Ports    : clk        - rising-edge clock for all state changes
//             rst        - synchronous active-high reset, clears every word
//             write_en   - write strobe, sampled at the rising edge
//             address    - word address shared by read and write
//             data_in    - write data
//             read_data  - combinational read of mem[address]
//
//  Revision : 1.0 - initial release
// ============================================================================
module memory #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] read_data
);

    // Storage array. Every address in the ADDR_WIDTH span maps to a word, so
    // no range checking or wrap logic is needed.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Reset takes priority over a write in the same cycle. An X/Z on rst or
    // write_en falls through the if-conditions as "not asserted", so a bench
    // that leaves either pin floating still sees a holding array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (write_en) begin
            r_mem[address] <= data_in;
        end
    end

    // Asynchronous read: a read of the address being written shows the old
    // word until the edge, then the new word immediately after it.
    always_comb begin
        read_data = r_mem[address];
    end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory
//  Purpose  : Self-checking bench for the memory block. Stimulus pushes the
//             expected read value into a scoreboard queue; a monitor pops and
//             compares on the falling edge whenever a check is flagged.
//
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    logic                  clk;
    logic                  rst;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] read_data;

    // Flags that the value on read_data this cycle must be compared.
    logic                  chk_valid;

    memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .address   (address),
        .data_in   (data_in),
        .read_data (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a plain array of words, updated at the moment a
    // write or reset is issued (it takes effect at the following edge).
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] ref_mem [0:DEPTH-1];

    typedef struct {
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
        int                    tag;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    function automatic string tag_name(input int t);
        case (t)
            0: return "reset_state";
            1: return "fill_old";
            2: return "readback";
            3: return "we_gating";
            4: return "rdw";
            5: return "boundary";
            6: return "reset_clear";
            7: return "post_reset";
            8: return "random";
            default: return "unknown";
        endcase
    endfunction

    // One clock of stimulus. Inputs change 1 time unit after the rising
    // edge; the monitor samples on the falling edge, i.e. before the edge
    // that would commit this cycle's write, so the expected value is the
    // model's current (pre-write) word.
    task automatic cycle(input logic [ADDR_WIDTH-1:0] a, input logic we,
                         input logic [DATA_WIDTH-1:0] d, input logic chk,
                         input int tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        address   = a;
        write_en  = we;
        data_in   = d;
        chk_valid = chk;
        if (chk) begin
            e.exp  = ref_mem[a];
            e.addr = a;
            e.tag  = tag;
            sb_q.push_back(e);
        end
        if (we) ref_mem[a] = d;
    endtask

    // Reset cycle with a competing write present on the pins; the write
    // must lose.
    task automatic do_reset(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        write_en  = 1'b1;
        address   = a;
        data_in   = d;
        chk_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (chk_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got %h at addr %0d, required a queued expectation",
                         read_data, address);
            end else begin
                e = sb_q.pop_front();
                if (read_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s: addr %0d got %h required %h",
                             tag_name(e.tag), e.addr, read_data, e.exp);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int errors_before_fill;
        rst       = 1'b0;
        write_en  = 1'b0;
        address   = '0;
        data_in   = '0;
        chk_valid = 1'b0;

        // Reset and confirm a spread of words read 0.
        do_reset(11'd0, 16'h0000);
        cycle(11'd0,    1'b0, 16'h0, 1'b1, 0);
        cycle(11'd1,    1'b0, 16'h0, 1'b1, 0);
        cycle(11'd1024, 1'b0, 16'h0, 1'b1, 0);
        cycle(11'd2047, 1'b0, 16'h0, 1'b1, 0);

        // Full write mem[i]=i, checking the pre-write (zero) value each cycle,
        // then read every address back.
        errors_before_fill = errors;
        for (int i = 0; i < DEPTH; i++)
            cycle(ADDR_WIDTH'(i), 1'b1, DATA_WIDTH'(i), 1'b1, 1);
        for (int i = 0; i < DEPTH; i++)
            cycle(ADDR_WIDTH'(i), 1'b0, 16'hDEAD, 1'b1, 2);
        cycle(11'd0, 1'b0, 16'h0, 1'b0, 2);
        if (errors == errors_before_fill) $display("No Errors Found!");

        // Write-enable gating.
        cycle(11'd5, 1'b1, 16'hAAAA, 1'b0, 3);
        for (int k = 0; k < 3; k++)
            cycle(11'd5, 1'b0, 16'h5555, 1'b1, 3);

        // Read-during-write: old value before the edge, new value after.
        cycle(11'd100, 1'b1, 16'h1234, 1'b0, 4);
        cycle(11'd100, 1'b1, 16'hBEEF, 1'b1, 4);
        cycle(11'd100, 1'b0, 16'h0000, 1'b1, 4);

        // Boundary addresses.
        cycle(11'd2047, 1'b1, 16'hFFFF, 1'b0, 5);
        cycle(11'd0,    1'b1, 16'h0001, 1'b0, 5);
        cycle(11'd2047, 1'b0, 16'h0, 1'b1, 5);
        cycle(11'd0,    1'b0, 16'h0, 1'b1, 5);
        cycle(11'd1,    1'b0, 16'h0, 1'b1, 5);
        cycle(11'd2046, 1'b0, 16'h0, 1'b1, 5);

        // Randomized traffic on a narrow address window so reads hit
        // recently written words often.
        for (int k = 0; k < 400; k++) begin
            logic [ADDR_WIDTH-1:0] a;
            a = (($urandom & 1) != 0) ? ADDR_WIDTH'($urandom_range(0, 15))
                                      : ADDR_WIDTH'($urandom_range(2032, 2047));
            cycle(a, 1'($urandom_range(0, 1)), DATA_WIDTH'($urandom), 1'b1, 8);
        end

        // Reset clears everything, including the word targeted by the
        // simultaneous write.
        for (int i = 0; i < 8; i++)
            cycle(ADDR_WIDTH'(i), 1'b1, DATA_WIDTH'(16'h1000 + i * 16'h0111), 1'b0, 6);
        do_reset(11'd3, 16'h7777);
        for (int i = 0; i < 8; i++)
            cycle(ADDR_WIDTH'(i), 1'b0, 16'h0, 1'b1, 6);
        cycle(11'd100,  1'b0, 16'h0, 1'b1, 6);
        cycle(11'd2047, 1'b0, 16'h0, 1'b1, 6);

        // Post-reset write.
        cycle(11'd9,  1'b1, 16'h0C0D, 1'b0, 7);
        cycle(11'd9,  1'b0, 16'h0, 1'b1, 7);
        cycle(11'd8,  1'b0, 16'h0, 1'b1, 7);
        cycle(11'd10, 1'b0, 16'h0, 1'b1, 7);
        cycle(11'd0,  1'b0, 16'h0, 1'b1, 7);

        // Drain: stop flagging checks and let the monitor catch up.
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        write_en  = 1'b0;
        repeat (2) @(negedge clk);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
